// File: rtl/alu_exec_ctrl_if.sv
// Execute-stage bus bundle: instruction handshake, ALU drive/return and memory port.
// master = controller side, slave = environment (decoder, ALU, memory).
interface alu_exec_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  alu_func;
  logic [15:0] alu_op0;
  logic [15:0] alu_op1;
  logic        alu_flag_en;
  logic [3:0]  alu_flag_in;
  logic [15:0] alu_q;
  logic [3:0]  alu_flag_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  instr, instr_valid, alu_q, alu_flag_out, mem_rdata, mem_ack,
    output instr_ready, alu_func, alu_op0, alu_op1, alu_flag_en, alu_flag_in,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output instr, instr_valid, alu_q, alu_flag_out, mem_rdata, mem_ack,
    input  instr_ready, alu_func, alu_op0, alu_op1, alu_flag_en, alu_flag_in,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: drives an external 16-bit ALU from an 8x16 register file,
// owns PC and NZCV flags, resolves branches and sequences LD/ST with a memory timeout.
module alu_exec_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  alu_exec_ctrl_if.master     bus,
  output logic [15:0]         pc,
  output logic [3:0]          flags,
  output logic                retire,
  output logic                mem_err,
  input  logic [2:0]          dbg_addr,
  output logic [15:0]         dbg_data
);

  localparam int unsigned DW = 16;
  localparam int unsigned RN = 8;
  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_LSL = 4'h2, OP_LSR = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_CMP = 4'h7,
    OP_MOV = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_JMP = 4'hB,
    OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_BLT = 4'hE, OP_BGT = 4'hF
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM} state_e;

  state_e          state;
  op_e             op_q;
  logic [2:0]      rd_q;
  logic [2:0]      ra_q;
  logic [CW-1:0]   tmo_cnt;
  logic [DW-1:0]   regs [RN];

  // Incoming instruction decode; r0 is never written so it always reads zero
  op_e             in_op;
  logic [DW-1:0]   in_opa;
  logic [DW-1:0]   in_opb;
  assign in_op    = op_e'(bus.instr[15:12]);
  assign in_opa   = regs[bus.instr[8:6]];
  assign in_opb   = bus.instr[5] ? DW'(bus.instr[4:0]) : regs[bus.instr[2:0]];
  assign dbg_data = regs[dbg_addr];

  // ALU drive selected per incoming op, registered on acceptance
  logic [DW-1:0] op0_c;
  logic [DW-1:0] op1_c;
  logic          flag_en_c;
  logic [3:0]    flag_in_c;

  always_comb begin
    op0_c     = in_opa;
    op1_c     = in_opb;
    flag_en_c = 1'b0;
    flag_in_c = flags;
    unique case (in_op)
      OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_CMP: flag_en_c = 1'b1;
      OP_MOV:                                                        op0_c = '0;
      OP_LD, OP_ST:                                                  ;
      OP_JMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGT:                        op1_c = '0;
    endcase
    if (in_op == OP_LD) flag_in_c = {1'b0, flags[2:0]};
  end

  // Branch resolution from the controller's own flags {C,N,V,Z}
  logic taken_c;
  always_comb begin
    taken_c = 1'b0;
    unique case (op_q)
      OP_JMP:  taken_c = 1'b1;
      OP_BEQ:  taken_c = flags[0];
      OP_BNE:  taken_c = ~flags[0];
      OP_BLT:  taken_c = flags[2] & ~flags[0];
      OP_BGT:  taken_c = ~flags[2] & ~flags[0];
      default: taken_c = 1'b0;
    endcase
  end

  logic tmo_hit_c;
  assign tmo_hit_c = (MEM_TIMEOUT != 0) && (tmo_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      bus.instr_ready <= 1'b1;
      pc              <= RESET_PC;
      flags           <= '0;
      retire          <= 1'b0;
      mem_err         <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.alu_func    <= '0;
      bus.alu_op0     <= '0;
      bus.alu_op1     <= '0;
      bus.alu_flag_en <= 1'b0;
      bus.alu_flag_in <= '0;
      op_q            <= OP_ADD;
      rd_q            <= '0;
      ra_q            <= '0;
      tmo_cnt         <= '0;
      for (int i = 0; i < RN; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            op_q            <= in_op;
            rd_q            <= bus.instr[11:9];
            ra_q            <= bus.instr[8:6];
            bus.alu_func    <= bus.instr[15:12];
            bus.alu_op0     <= op0_c;
            bus.alu_op1     <= op1_c;
            bus.alu_flag_en <= flag_en_c;
            bus.alu_flag_in <= flag_in_c;
            bus.instr_ready <= 1'b0;
            state           <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (op_q)
            OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_XOR: begin
              if (rd_q != 3'd0) regs[rd_q] <= bus.alu_q;
              flags <= bus.alu_flag_out;
            end
            OP_CMP: flags <= bus.alu_flag_out;
            OP_MOV: if (rd_q != 3'd0) regs[rd_q] <= bus.alu_q;
            OP_LD, OP_ST: begin
              bus.mem_addr <= bus.alu_q;
              if (op_q == OP_ST) bus.mem_wdata <= regs[rd_q];
              bus.mem_req  <= 1'b1;
              bus.mem_we   <= (op_q == OP_ST);
              tmo_cnt      <= '0;
            end
            OP_JMP, OP_BEQ, OP_BNE, OP_BLT, OP_BGT: ;
          endcase
          if (op_q == OP_LD || op_q == OP_ST) begin
            state <= S_MEM;
          end else begin
            pc              <= taken_c ? regs[ra_q] : pc + DW'(1);
            retire          <= 1'b1;
            bus.instr_ready <= 1'b1;
            state           <= S_IDLE;
          end
        end
        S_MEM: begin
          // Ack wins over a coincident timeout; abort leaves the register file untouched
          if (bus.mem_ack || tmo_hit_c) begin
            if (bus.mem_ack && op_q == OP_LD && rd_q != 3'd0) regs[rd_q] <= bus.mem_rdata;
            if (!bus.mem_ack) mem_err <= 1'b1;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            pc              <= pc + DW'(1);
            retire          <= 1'b1;
            bus.instr_ready <= 1'b1;
            state           <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: behavioural ALU, programmable-latency memory
// responder, and hand-computed expectations for each instruction sequence.
module tb_alu_exec_ctrl;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, LSL = 4'h2, LSR = 4'h3,
                         AND = 4'h4, OR  = 4'h5, XOR = 4'h6, CMP = 4'h7,
                         MOV = 4'h8, LD  = 4'h9, ST  = 4'hA, JMP = 4'hB,
                         BEQ = 4'hC, BNE = 4'hD, BLT = 4'hE, BGT = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        retire;
  logic        mem_err;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl #(.RESET_PC(16'h0000), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .flags(flags), .retire(retire),
    .mem_err(mem_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; flags {C,N,V,Z}, C on subtract means no borrow, LD/ST add carry-in
  always_comb begin
    logic [16:0] s;
    logic        c, v;
    s = 17'h0;
    c = 1'b0;
    v = 1'b0;
    case (bus.alu_func)
      ADD: begin s = {1'b0, bus.alu_op0} + {1'b0, bus.alu_op1}; c = s[16];
             v = (bus.alu_op0[15] == bus.alu_op1[15]) && (s[15] != bus.alu_op0[15]); end
      SUB, CMP: begin s = {1'b0, bus.alu_op0 - bus.alu_op1}; c = (bus.alu_op0 >= bus.alu_op1);
             v = (bus.alu_op0[15] != bus.alu_op1[15]) && (s[15] != bus.alu_op0[15]); end
      LSL: s = {1'b0, bus.alu_op0 << bus.alu_op1[3:0]};
      LSR: s = {1'b0, bus.alu_op0 >> bus.alu_op1[3:0]};
      AND: s = {1'b0, bus.alu_op0 & bus.alu_op1};
      OR:  s = {1'b0, bus.alu_op0 | bus.alu_op1};
      XOR: s = {1'b0, bus.alu_op0 ^ bus.alu_op1};
      MOV: s = {1'b0, bus.alu_op1};
      LD, ST: s = {1'b0, bus.alu_op0 + bus.alu_op1 + 16'(bus.alu_flag_in[3])};
      default: s = {1'b0, bus.alu_op0 + bus.alu_op1};
    endcase
    bus.alu_q        = s[15:0];
    bus.alu_flag_out = bus.alu_flag_en ? {c, s[15], v, (s[15:0] == 16'h0)} : bus.alu_flag_in;
  end

  // Memory responder: acks after resp_wait idle request cycles (negative = never)
  int          resp_wait = -1;
  logic [15:0] resp_data = 16'h0;
  int          req_cur = 0;
  int          req_len = 0;
  logic [15:0] cap_addr, cap_wdata;
  logic        cap_we;

  always @(negedge clk) begin
    if (bus.mem_req) begin
      req_cur = req_cur + 1;
      if (req_cur == 1) begin
        cap_addr  = bus.mem_addr;
        cap_wdata = bus.mem_wdata;
        cap_we    = bus.mem_we;
      end
      bus.mem_ack   = (resp_wait >= 0) && (req_cur == resp_wait + 1);
      bus.mem_rdata = resp_data;
    end else begin
      if (req_cur != 0) req_len = req_cur;
      req_cur     = 0;
      bus.mem_ack = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    check_eq(tag, 32'(dbg_data), 32'(exp));
  endtask

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [4:0] imm);
    return {op, rd, ra, 1'b1, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, 1'b0, 2'b00, rb};
  endfunction

  task automatic issue(input logic [15:0] ins);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("issue_ready_timeout", 32'(bus.instr_ready), 32'd1);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  task automatic wait_retire(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!retire && lat < 40);
    if (!retire) check_eq("retire_timeout", 32'(retire), 32'd1);
    #1;
  endtask

  task automatic run(input logic [15:0] ins, output int lat);
    issue(ins);
    wait_retire(lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int acc;
    bus.instr       = 16'h0;
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_pc", 32'(pc), 32'h0000);
    check_eq("rst_flags", 32'(flags), 32'h0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(bus.instr_ready), 32'd1);
    check_eq("rst_retire", 32'(retire), 32'd0);
    check_eq("rst_mem_err", 32'(mem_err), 32'd0);
    check_reg("rst_r1", 3'd1, 16'h0000);

    // r1 = FFFF through memory so flags stay 0, then ADD r3 = r1 + r2
    resp_wait = 0; resp_data = 16'hFFFF;
    run(enc_i(LD, 3'd1, 3'd0, 5'd0), lat);
    check_reg("ld_r1", 3'd1, 16'hFFFF);
    check_eq("ld_flags", 32'(flags), 32'h0);
    run(enc_i(MOV, 3'd2, 3'd0, 5'd1), lat);
    check_eq("mov_pc", 32'(pc), 32'h0002);
    run(enc_r(ADD, 3'd3, 3'd1, 3'd2), lat);
    check_eq("add_latency", 32'(lat), 32'd2);
    check_reg("add_r3", 3'd3, 16'h0000);
    check_eq("add_flags", 32'(flags), 32'h9);
    check_eq("add_pc", 32'(pc), 32'h0003);

    // r4 = 0x40, CMP equal, BEQ taken then BNE not taken
    run(enc_i(MOV, 3'd4, 3'd0, 5'd16), lat);
    run(enc_i(LSL, 3'd4, 3'd4, 5'd2), lat);
    check_reg("lsl_r4", 3'd4, 16'h0040);
    run(enc_i(MOV, 3'd1, 3'd0, 5'd5), lat);
    run(enc_i(MOV, 3'd2, 3'd0, 5'd5), lat);
    run(enc_r(CMP, 3'd3, 3'd1, 3'd2), lat);
    check_eq("cmp_eq_flags", 32'(flags), 32'h9);
    check_reg("cmp_no_wb", 3'd3, 16'h0000);
    run(enc_r(BEQ, 3'd0, 3'd4, 3'd0), lat);
    check_eq("beq_taken_pc", 32'(pc), 32'h0040);
    check_eq("beq_flags", 32'(flags), 32'h9);
    run(enc_r(CMP, 3'd0, 3'd1, 3'd2), lat);
    run(enc_r(BNE, 3'd0, 3'd4, 3'd0), lat);
    check_eq("bne_fall_pc", 32'(pc), 32'h0042);

    // 5 - 6: N=1, Z=0 -> BGT falls through, BLT taken
    run(enc_i(CMP, 3'd0, 3'd2, 5'd6), lat);
    check_eq("cmp_lt_flags", 32'(flags), 32'h4);
    run(enc_r(BGT, 3'd0, 3'd4, 3'd0), lat);
    check_eq("bgt_fall_pc", 32'(pc), 32'h0044);
    run(enc_r(BLT, 3'd0, 3'd4, 3'd0), lat);
    check_eq("blt_taken_pc", 32'(pc), 32'h0040);

    // LD with C=1 in flags: address must not absorb the carry
    run(enc_i(MOV, 3'd1, 3'd0, 5'd16), lat);
    run(enc_i(CMP, 3'd0, 3'd1, 5'd0), lat);
    check_eq("cmp_c_flags", 32'(flags), 32'h8);
    resp_wait = 4; resp_data = 16'hBEEF;
    run(enc_i(LD, 3'd5, 3'd1, 5'd3), lat);
    check_eq("ld_addr", 32'(cap_addr), 32'h0013);
    check_eq("ld_we", 32'(cap_we), 32'd0);
    check_eq("ld_req_len", 32'(req_len), 32'd5);
    check_reg("ld_r5", 3'd5, 16'hBEEF);
    check_eq("ld_flags_kept", 32'(flags), 32'h8);
    check_eq("ld_pc", 32'(pc), 32'h0043);
    check_eq("ld_no_err", 32'(mem_err), 32'd0);

    // ST with no ack: timeout after 15 request cycles
    run(enc_i(CMP, 3'd0, 3'd2, 5'd6), lat);
    resp_wait = -1;
    run(enc_i(ST, 3'd5, 3'd1, 5'd1), lat);
    check_eq("st_addr", 32'(cap_addr), 32'h0011);
    check_eq("st_wdata", 32'(cap_wdata), 32'hBEEF);
    check_eq("st_we", 32'(cap_we), 32'd1);
    check_eq("st_req_len", 32'(req_len), 32'd15);
    check_eq("st_mem_err", 32'(mem_err), 32'd1);
    check_eq("st_pc", 32'(pc), 32'h0045);
    check_reg("st_r5_kept", 3'd5, 16'hBEEF);

    // instr_valid held high: one acceptance per IDLE cycle
    acc = 0;
    @(negedge clk);
    bus.instr       = enc_i(ADD, 3'd6, 3'd6, 5'd1);
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bus.instr_ready) acc++;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    check_eq("b2b_accepts", 32'(acc), 32'd3);
    check_reg("b2b_r6", 3'd6, 16'h0003);
    check_eq("b2b_pc", 32'(pc), 32'h0048);
    check_eq("mem_err_sticky", 32'(mem_err), 32'd1);
    run(enc_i(MOV, 3'd0, 3'd0, 5'd7), lat);
    check_reg("r0_zero", 3'd0, 16'h0000);
    check_eq("mov_r0_pc", 32'(pc), 32'h0049);

    // PC wrap FFFF -> 0000
    run(enc_i(MOV, 3'd1, 3'd0, 5'd0), lat);
    run(enc_i(SUB, 3'd1, 3'd1, 5'd1), lat);
    check_reg("sub_r1", 3'd1, 16'hFFFF);
    run(enc_r(JMP, 3'd0, 3'd1, 3'd0), lat);
    check_eq("jmp_pc", 32'(pc), 32'hFFFF);
    run(enc_i(MOV, 3'd2, 3'd0, 5'd1), lat);
    check_eq("pc_wrap", 32'(pc), 32'h0000);

    // Reset while a load is waiting in MEM
    run(enc_i(CMP, 3'd0, 3'd0, 5'd1), lat);
    issue(enc_i(LD, 3'd7, 3'd0, 5'd0));
    repeat (3) @(negedge clk);
    check_eq("mid_mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mem_req_drop", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mid_pc", 32'(pc), 32'h0000);
    check_eq("rst_mid_flags", 32'(flags), 32'h0);
    check_eq("rst_mid_mem_err", 32'(mem_err), 32'd0);
    check_reg("rst_mid_r5", 3'd5, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
    check_reg("rst_mid_r7", 3'd7, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage controller that drives the 16-bit ALU's func/OP0/OP1/flag_en/flag_in inputs and consumes its Q/flag_out outputs. It accepts one instruction word per valid/ready handshake and reads operands from an internal 8x16 register file. It owns the NZCV flag register and PC, resolves branches itself, and sequences LD/ST through a req/ack memory port with timeout.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
MEM_TIMEOUT, 15, max MEM-state cycles without mem_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr  in  16  instruction: [15:12] op (ALU func code), [11:9] rd, [8:6] ra, [5] imm_sel, [4:0] imm5 / [2:0] rb
instr_valid  in  1  instr present
instr_ready  out  1  controller can accept
alu_func  out  4  to ALU func
alu_op0  out  16  to ALU OP0
alu_op1  out  16  to ALU OP1
alu_flag_en  out  1  to ALU flag_en
alu_flag_in  out  4  to ALU flag_in {C,N,V,Z}
alu_q  in  16  ALU Q
alu_flag_out  in  4  ALU flag_out
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  16  address
mem_wdata  out  16  store data
mem_rdata  in  16  load data, valid with mem_ack
mem_ack  in  1  completes request
pc  out  16  program counter
flags  out  4  flag register {C,N,V,Z}
retire  out  1  one-cycle pulse per completed instruction
mem_err  out  1  sticky timeout error
dbg_addr  in  3  debug register index
dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async, immediate): state IDLE; pc=RESET_PC; flags=0; all regs=0; mem_req=0, mem_we=0, retire=0, mem_err=0; alu_* outputs and mem_addr/mem_wdata=0. Reset during MEM drops mem_req in the same cycle; the in-flight access is abandoned with no writeback.
- r0 reads as 0; writes to r0 are discarded.
- opB = imm_sel ? zero-extended imm5 : reg[rb].
- States: IDLE, EXEC, MEM.
- IDLE: instr_ready=1. On instr_valid, register the instr and drive alu_* from registered values, then go to EXEC. alu_* outputs are registered and stay stable for all of EXEC.
- ALU drive per op:
  - ADD/SUB/LSL/LSR/AND/OR/XOR: op0=reg[ra], op1=opB, flag_en=1.
  - CMP: op0=reg[ra], op1=opB.
  - MOV: op0=0, op1=opB, flag_en=0.
  - LD/ST: op0=reg[ra], op1=opB, flag_en=0.
  - JMP/branches: op0=reg[ra], op1=0.
- alu_flag_in = flags, except for LD, where bit3 is forced to 0 so the address carries no carry-in.
- EXEC (exactly 1 cycle). On the edge ending EXEC:
  - ADD..XOR: rd <= alu_q and flags <= alu_flag_out.
  - CMP: flags only.
  - MOV: rd <= alu_q.
  - LD/ST: latch mem_addr=alu_q; ST also latches mem_wdata=reg[rd]; go to MEM with mem_req=1 and mem_we=(op==ST).
  - Branch: the controller evaluates the condition from its own flags. BEQ: Z=1. BNE: Z=0. BLT: N=1 & Z=0. BGT: N=0 & Z=0. JMP is always taken. Taken: pc <= reg[ra]. Not taken: pc <= pc+1.
  - All non-memory ops: pc <= pc+1 unless a branch was taken, retire pulses, return to IDLE.
- Latency: non-memory ops retire 2 cycles after acceptance. instr_ready is low during EXEC/MEM, so the next acceptance is no earlier than 2 cycles after the previous one.
- MEM: hold mem_req/mem_we/mem_addr/mem_wdata stable until mem_ack.
  - On ack: LD writes rd <= mem_rdata; pc <= pc+1; retire; return to IDLE; mem_req falls next cycle.
  - A timeout counter resets on entry to MEM. If the counter reaches MEM_TIMEOUT with no ack: mem_req drops, mem_err sets (sticky until reset), no writeback, pc <= pc+1, retire, return to IDLE.
  - mem_ack outside MEM is ignored.
- PC wraps FFFF->0000 modulo 2^16. Register arithmetic width is defined by the ALU; the controller adds no extension bits.
- Flags change only on ADD..XOR and CMP retirement.

Test Plan:
- flags=0; r1=FFFF, r2=0001; ADD r3,r1,r2 -> r3=0000, flags C=1,Z=1; retire at cycle 2; pc 0->1.
- r1=0005, MOV r2,#5, CMP r1,r2, then BEQ r4 (r4=0040) -> pc=0040; same sequence with BNE -> pc=prev+1.
- LD r5,[r1+#3], r1=0010: mem_addr=0013, ack after 4 wait cycles with rdata=BEEF -> r5=BEEF, mem_req high exactly 5 cycles, flags unchanged.
- ST with no ack, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles, mem_err=1, retire pulses, rd unchanged.
- rst asserted mid-MEM -> mem_req=0 immediately, pc=RESET_PC, regs and flags 0, instr_ready=1 after rst falls.
- instr_valid held high across back-to-back ADDs; MOV r0,#7 -> exactly one acceptance per IDLE; r0 still reads 0.
